// File: rtl/uart_cmd_decoder.sv
// UART command decoder: parses WRITE/FILL/PING packets into framebuffer writes
// and answers every packet with a single ACK/NAK byte.
module uart_cmd_decoder #(
    parameter int unsigned FB_WORDS     = 64000,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned TIMEOUT_CLKS = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              fill_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [7:0]        err_count
);

    typedef enum logic [2:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StData,
        StFillColor,
        StFill,
        StResp
    } state_e;

    localparam int unsigned       TimerW   = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CLKS - 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_WORDS - 1);
    localparam logic [7:0]        Ack      = 8'h06;
    localparam logic [7:0]        Nak      = 8'h15;

    state_e              state_q;
    logic [15:0]         addr_q;
    logic [7:0]          resp_q;
    logic [TimerW-1:0]   timer_q;
    logic [7:0]          err_q, err_d;
    logic                wr_en_q, fill_busy_q, tx_start_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [7:0]          wr_data_q, tx_data_q;
    logic                in_pkt, timeout_hit, addr_ok, err_inc;

    always_comb begin
        in_pkt      = (state_q == StAddrHi) || (state_q == StAddrLo) ||
                      (state_q == StData) || (state_q == StFillColor);
        timeout_hit = in_pkt && !rx_data_valid && (timer_q == TimerMax);
        addr_ok     = 32'(addr_q) < FB_WORDS;
        err_inc     = 1'b0;
        unique case (state_q)
            StIdle:      err_inc = rx_data_valid &&
                                   !(rx_data inside {8'h01, 8'h02, 8'h03});
            StAddrHi,
            StAddrLo,
            StFillColor: err_inc = timeout_hit;
            StData:      err_inc = timeout_hit || (rx_data_valid && !addr_ok);
            StFill,
            StResp:      err_inc = rx_data_valid;
            default:     err_inc = 1'b0;
        endcase
        // A single flag per cycle, so coincident error sources count once
        err_d = (err_inc && err_q != 8'hff) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            resp_q      <= '0;
            timer_q     <= '0;
            err_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fill_busy_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            err_q      <= err_d;
            wr_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            timer_q    <= '0;
            if (in_pkt && !rx_data_valid && !timeout_hit) begin
                timer_q <= timer_q + TimerW'(1);
            end
            if (timeout_hit) begin
                resp_q  <= Nak;
                state_q <= StResp;
            end
            case (state_q)
                StIdle: begin
                    if (rx_data_valid) begin
                        case (rx_data)
                            8'h01:   state_q <= StAddrHi;
                            8'h02:   state_q <= StFillColor;
                            8'h03: begin
                                resp_q  <= Ack;
                                state_q <= StResp;
                            end
                            default: begin
                                resp_q  <= Nak;
                                state_q <= StResp;
                            end
                        endcase
                    end
                end
                StAddrHi: begin
                    if (rx_data_valid) begin
                        addr_q[15:8] <= rx_data;
                        state_q      <= StAddrLo;
                    end
                end
                StAddrLo: begin
                    if (rx_data_valid) begin
                        addr_q[7:0] <= rx_data;
                        state_q     <= StData;
                    end
                end
                StData: begin
                    if (rx_data_valid) begin
                        if (addr_ok) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= ADDR_W'(addr_q);
                            wr_data_q <= rx_data;
                            resp_q    <= Ack;
                        end else begin
                            resp_q <= Nak;
                        end
                        state_q <= StResp;
                    end
                end
                StFillColor: begin
                    // The first fill write is issued together with fill_busy
                    if (rx_data_valid) begin
                        wr_en_q     <= 1'b1;
                        wr_addr_q   <= '0;
                        wr_data_q   <= rx_data;
                        fill_busy_q <= 1'b1;
                        state_q     <= StFill;
                    end
                end
                StFill: begin
                    if (wr_addr_q == LastAddr) begin
                        fill_busy_q <= 1'b0;
                        resp_q      <= Ack;
                        state_q     <= StResp;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_addr_q + ADDR_W'(1);
                    end
                end
                StResp: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= resp_q;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign fill_busy = fill_busy_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with write/response scoreboards.
module tb_uart_cmd_decoder;

    localparam int unsigned FbWords = 64000;
    localparam int unsigned AddrW   = 16;
    localparam int unsigned Tmo     = 1000;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       rx_data;
    logic             rx_data_valid;
    logic             wr_en;
    logic [AddrW-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic             fill_busy;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy;
    logic [7:0]       err_count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int exp_err = 0;
    int n;
    logic [24:0] wq[$];
    logic [7:0]  tq[$];

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .FB_WORDS    (FbWords),
        .ADDR_W      (AddrW),
        .TIMEOUT_CLKS(Tmo)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .fill_busy    (fill_busy),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .err_count    (err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write and every response byte must match the next expected entry
    logic [24:0] we;
    logic [7:0]  te;
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (wq.size() == 0) chk("unexpected_wr", 64'(wr_en), 64'd0);
                else begin
                    we = wq.pop_front();
                    chk("wr_busy_addr_data", {39'd0, fill_busy, wr_addr, wr_data}, {39'd0, we});
                end
            end
            if (tx_start) begin
                if (tq.size() == 0) chk("unexpected_tx", 64'(tx_start), 64'd0);
                else begin
                    te = tq.pop_front();
                    chk("tx_busy_data", {55'd0, tx_busy, tx_data}, {56'd0, te});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
    endtask

    task automatic drain(input int limit, output int cyc);
        cyc = 0;
        while ((wq.size() != 0 || tq.size() != 0) && cyc < limit) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("drain_pending", 64'(wq.size() + tq.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset         = 1'b1;
        rx_data_valid = 1'b0;
        tx_busy       = 1'b0;
        repeat (2) @(negedge clk);
        wq.delete();
        tq.delete();
        exp_err = 0;
        reset   = 1'b0;
    endtask

    task automatic chk_err();
        chk("err_count", 64'(err_count), 64'((exp_err > 255) ? 255 : exp_err));
    endtask

    initial begin
        reset         = 1'b1;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        tx_busy       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {61'd0, wr_en, fill_busy, tx_start}, 64'd0);
        chk("rst_data", {24'd0, wr_addr, wr_data, tx_data, err_count}, 64'd0);
        reset = 1'b0;

        // Single write with exact one-cycle latency
        send(8'h01); send(8'h12); send(8'h34);
        wq.push_back({1'b0, 16'h1234, 8'hAB});
        tq.push_back(8'h06);
        send(8'hAB);
        chk("wr_latency", 64'(wr_en), 64'd1);
        drain(50, n);
        chk_err();

        // Out-of-range address is rejected, last valid address accepted
        apply_reset();
        tq.push_back(8'h15);
        exp_err++;
        send(8'h01); send(8'hFA); send(8'h00); send(8'h55);
        drain(50, n);
        chk_err();
        wq.push_back({1'b0, 16'hF9FF, 8'h77});
        tq.push_back(8'h06);
        send(8'h01); send(8'hF9); send(8'hFF); send(8'h77);
        drain(50, n);
        chk_err();

        // Full fill sweep with a byte dropped mid-fill
        apply_reset();
        for (int i = 0; i < int'(FbWords); i++) wq.push_back({1'b1, 16'(i), 8'h3C});
        tq.push_back(8'h06);
        send(8'h02); send(8'h3C);
        repeat (100) @(negedge clk);
        exp_err++;
        send(8'h03);
        drain(70000, n);
        chk("fill_busy_after", 64'(fill_busy), 64'd0);
        chk_err();
        tq.push_back(8'h06);
        send(8'h03);
        drain(50, n);

        // Inter-byte timeout, and gaps just under the limit must not time out
        apply_reset();
        tq.push_back(8'h15);
        exp_err++;
        send(8'h01); send(8'h12);
        drain(Tmo + 50, n);
        chk("timeout_window", 64'((n >= int'(Tmo)) && (n <= int'(Tmo) + 2)), 64'd1);
        chk_err();
        tq.push_back(8'h06);
        send(8'h03);
        drain(50, n);
        wq.push_back({1'b0, 16'h1234, 8'h56});
        tq.push_back(8'h06);
        send(8'h01);
        repeat (Tmo - 100) @(negedge clk);
        send(8'h12);
        repeat (Tmo - 100) @(negedge clk);
        send(8'h34);
        repeat (Tmo - 100) @(negedge clk);
        send(8'h56);
        drain(50, n);
        chk_err();

        // Transmitter back-pressure, NAK on bad opcode, error saturation
        apply_reset();
        tx_busy = 1'b1;
        tq.push_back(8'h06);
        send(8'h03);
        repeat (100) @(negedge clk);
        chk("tx_held_off", 64'(tq.size()), 64'd1);
        tx_busy = 1'b0;
        drain(10, n);
        chk("tx_launch_delay", 64'(n <= 2), 64'd1);
        tq.push_back(8'h15);
        exp_err++;
        send(8'h7F);
        drain(50, n);
        chk_err();
        for (int i = 0; i < 300; i++) begin
            logic [7:0] b;
            b = 8'h80 | 8'(i % 128);
            tq.push_back(8'h15);
            exp_err++;
            send(b);
            drain(20, n);
        end
        chk_err();

        // Reset during a fill aborts it silently
        apply_reset();
        for (int i = 0; i < int'(FbWords); i++) wq.push_back({1'b1, 16'(i), 8'h55});
        tq.push_back(8'h06);
        send(8'h02); send(8'h55);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ctrl", {61'd0, wr_en, fill_busy, tx_start}, 64'd0);
        chk("abort_err", 64'(err_count), 64'd0);
        @(negedge clk);
        wq.delete();
        tq.delete();
        reset = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_idle", {61'd0, wr_en, fill_busy, tx_start}, 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
